// File: rtl/diamond_pkg.sv
// Shared diamond layout and scan FSM encoding for the collector and display logic.
// Positions are top-left pixels of each 20x20 diamond sprite.
package diamond_pkg;

  localparam int DIAMOND_SIZE = 20;
  localparam int NUM_DIAMONDS = 6;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } point_t;

  // 0..2 blue (watergirl), 3..5 red (fireboy)
  function automatic point_t diamond_pos(input logic [2:0] idx);
    point_t p;
    case (idx)
      3'd0:    begin p.x = 10'd460; p.y = 10'd408; end
      3'd1:    begin p.x = 10'd366; p.y = 10'd238; end
      3'd2:    begin p.x = 10'd38;  p.y = 10'd90;  end
      3'd3:    begin p.x = 10'd330; p.y = 10'd408; end
      3'd4:    begin p.x = 10'd300; p.y = 10'd220; end
      default: begin p.x = 10'd190; p.y = 10'd42;  end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Player-vs-diamond box overlap test; strict inequalities, so touching edges miss.
// Sums are widened to 11 bits so boxes near the screen edge never wrap.
module aabb_overlap
  import diamond_pkg::*;
#(
  parameter int PLAYER_W = 20,
  parameter int PLAYER_H = 28
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] dx,
  input  logic [9:0] dy,
  output logic       hit
);

  logic [10:0] px_w, py_w, dx_w, dy_w;

  assign px_w = {1'b0, px};
  assign py_w = {1'b0, py};
  assign dx_w = {1'b0, dx};
  assign dy_w = {1'b0, dy};

  assign hit = (px_w < dx_w + 11'(DIAMOND_SIZE))
            && (px_w + 11'(PLAYER_W) > dx_w)
            && (py_w < dy_w + 11'(DIAMOND_SIZE))
            && (py_w + 11'(PLAYER_H) > dy_w);

endmodule

// File: rtl/diamond_collector.sv
// Per-frame diamond pickup scan: one diamond per cycle against latched positions.
// Score counters exist only when DIAMOND_SCORE_EN is defined.
module diamond_collector
  import diamond_pkg::*;
#(
  parameter int PLAYER_W = 20,
  parameter int PLAYER_H = 28
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       level_restart,
  input  logic [9:0] fire_x,
  input  logic [9:0] fire_y,
  input  logic [9:0] water_x,
  input  logic [9:0] water_y,
  output logic       is_diamond_eat1,
  output logic       is_diamond_eat2,
  output logic       is_diamond_eat3,
  output logic       is_diamond_eat1_red,
  output logic       is_diamond_eat1_red1,
  output logic       is_diamond_eat1_red2,
  output logic [1:0] blue_count,
  output logic [1:0] red_count,
  output logic       collect_pulse,
  output logic       all_collected
);

  scan_state_t state;
  logic [2:0]  idx;
  logic        frame_q;
  logic [9:0]  fx_q, fy_q, wx_q, wy_q;
  logic [5:0]  eaten;
  logic        frame_edge;
  logic        is_blue;
  logic        hit;
  logic        new_hit;
  point_t      dpos;
  logic [9:0]  px, py;

  assign frame_edge = frame_clk & ~frame_q;
  assign dpos       = diamond_pos(idx);
  assign is_blue    = idx < 3'd3;
  assign px         = is_blue ? wx_q : fx_q;
  assign py         = is_blue ? wy_q : fy_q;
  assign new_hit    = (state == SCAN) && hit && !eaten[idx];

  aabb_overlap #(
    .PLAYER_W (PLAYER_W),
    .PLAYER_H (PLAYER_H)
  ) u_overlap (
    .px  (px),
    .py  (py),
    .dx  (dpos.x),
    .dy  (dpos.y),
    .hit (hit)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      idx           <= '0;
      frame_q       <= 1'b0;
      eaten         <= '0;
      collect_pulse <= 1'b0;
      all_collected <= 1'b0;
      fx_q          <= '0;
      fy_q          <= '0;
      wx_q          <= '0;
      wy_q          <= '0;
    end else begin
      frame_q       <= frame_clk;
      collect_pulse <= 1'b0;
      if (level_restart) begin
        state         <= IDLE;
        idx           <= '0;
        eaten         <= '0;
        all_collected <= 1'b0;
      end else begin
        case (state)
          IDLE: if (frame_edge) begin
            state <= SCAN;
            idx   <= '0;
            fx_q  <= fire_x;
            fy_q  <= fire_y;
            wx_q  <= water_x;
            wy_q  <= water_y;
          end
          SCAN: begin
            if (new_hit) begin
              eaten[idx]    <= 1'b1;
              collect_pulse <= 1'b1;
            end
            if (idx == 3'(NUM_DIAMONDS - 1)) state <= DONE;
            else idx <= idx + 3'd1;
          end
          DONE: begin
            all_collected <= &eaten;
            state         <= IDLE;
            idx           <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DIAMOND_SCORE_EN
  logic [1:0] blue_q, red_q;

  always_ff @(posedge Clk) begin
    if (Reset || level_restart) begin
      blue_q <= '0;
      red_q  <= '0;
    end else if (new_hit) begin
      if (is_blue && blue_q != 2'd3) blue_q <= blue_q + 2'd1;
      if (!is_blue && red_q != 2'd3) red_q <= red_q + 2'd1;
    end
  end

  assign blue_count = blue_q;
  assign red_count  = red_q;
`else
  assign blue_count = '0;
  assign red_count  = '0;
`endif

  assign is_diamond_eat1      = eaten[0];
  assign is_diamond_eat2      = eaten[1];
  assign is_diamond_eat3      = eaten[2];
  assign is_diamond_eat1_red  = eaten[3];
  assign is_diamond_eat1_red1 = eaten[4];
  assign is_diamond_eat1_red2 = eaten[5];

endmodule

// File: tb/tb_diamond_collector.sv
// Bench for diamond_collector: directed frames plus random player positions,
// checked cycle by cycle against a box-overlap model of the collection rules.
module tb_diamond_collector;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       level_restart;
  logic [9:0] fire_x, fire_y, water_x, water_y;
  logic       is_diamond_eat1, is_diamond_eat2, is_diamond_eat3;
  logic       is_diamond_eat1_red, is_diamond_eat1_red1, is_diamond_eat1_red2;
  logic [1:0] blue_count, red_count;
  logic       collect_pulse, all_collected;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  int dia_x [6] = '{460, 366, 38, 330, 300, 190};
  int dia_y [6] = '{408, 238, 90, 408, 220, 42};
  bit exp_eaten [6];

  always #5 Clk = ~Clk;

  diamond_collector dut (
    .Clk                  (Clk),
    .Reset                (Reset),
    .frame_clk            (frame_clk),
    .level_restart        (level_restart),
    .fire_x               (fire_x),
    .fire_y               (fire_y),
    .water_x              (water_x),
    .water_y              (water_y),
    .is_diamond_eat1      (is_diamond_eat1),
    .is_diamond_eat2      (is_diamond_eat2),
    .is_diamond_eat3      (is_diamond_eat3),
    .is_diamond_eat1_red  (is_diamond_eat1_red),
    .is_diamond_eat1_red1 (is_diamond_eat1_red1),
    .is_diamond_eat1_red2 (is_diamond_eat1_red2),
    .blue_count           (blue_count),
    .red_count            (red_count),
    .collect_pulse        (collect_pulse),
    .all_collected        (all_collected)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit overl(int px, int py, int dx, int dy);
    return (px < dx + 20) && (px + 20 > dx) && (py < dy + 20) && (py + 28 > dy);
  endfunction

  function automatic logic [5:0] dut_flags();
    return {is_diamond_eat1_red2, is_diamond_eat1_red1, is_diamond_eat1_red,
            is_diamond_eat3, is_diamond_eat2, is_diamond_eat1};
  endfunction

  function automatic logic [5:0] exp_flags();
    logic [5:0] v;
    for (int k = 0; k < 6; k++) v[k] = exp_eaten[k];
    return v;
  endfunction

  function automatic int exp_cnt(int base);
    int n = 0;
    for (int k = 0; k < 3; k++) n += int'(exp_eaten[base + k]);
`ifdef DIAMOND_SCORE_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_flags"}, 32'(dut_flags()), 32'(exp_flags()));
    chk({tag, "_blue"}, 32'(blue_count), 32'(exp_cnt(0)));
    chk({tag, "_red"}, 32'(red_count), 32'(exp_cnt(3)));
  endtask

  task automatic clear_model();
    for (int k = 0; k < 6; k++) exp_eaten[k] = 1'b0;
  endtask

  // abort_kind: 0 none, 1 level_restart, 2 Reset, driven at step abort_j
  task automatic run_frame(input string tag, input int fx, input int fy,
                           input int wx, input int wy, input int abort_kind,
                           input int abort_j, input int ghost_j);
    bit newc [6];
    bit aborted = 1'b0;
    bit exp_pulse;
    for (int k = 0; k < 6; k++)
      newc[k] = !exp_eaten[k] &&
        (k < 3 ? overl(wx, wy, dia_x[k], dia_y[k])
               : overl(fx, fy, dia_x[k], dia_y[k]));
    @(negedge Clk);
    fire_x  = 10'(fx);
    fire_y  = 10'(fy);
    water_x = 10'(wx);
    water_y = 10'(wy);
    frame_clk = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge Clk);
      if (j == 1) begin
        frame_clk = 1'b0;
        fire_x  = 10'($urandom_range(619));
        fire_y  = 10'($urandom_range(451));
        water_x = 10'($urandom_range(619));
        water_y = 10'($urandom_range(451));
      end
      if (abort_kind != 0 && j == abort_j + 1) begin
        level_restart = 1'b0;
        Reset = 1'b0;
        aborted = 1'b1;
        clear_model();
      end
      exp_pulse = !aborted && j >= 2 && j <= 7 && newc[j-2];
      if (exp_pulse) exp_eaten[j-2] = 1'b1;
      chk($sformatf("%s_pulse_c%0d", tag, j), 32'(collect_pulse), 32'(exp_pulse));
      chk_state($sformatf("%s_c%0d", tag, j));
      if (j == 8)
        chk({tag, "_all"}, 32'(all_collected), 32'(!aborted && &exp_flags()));
      if (abort_kind == 1 && j == abort_j) level_restart = 1'b1;
      if (abort_kind == 2 && j == abort_j) Reset = 1'b1;
      if (j == ghost_j) begin
        frame_clk = 1'b1;
        water_x = 10'd455; water_y = 10'd400;
        fire_x  = 10'd325; fire_y  = 10'd400;
      end
      if (j == ghost_j + 1) frame_clk = 1'b0;
    end
  endtask

  task automatic restart(input string tag);
    @(negedge Clk);
    level_restart = 1'b1;
    @(negedge Clk);
    level_restart = 1'b0;
    clear_model();
    chk({tag, "_pulse"}, 32'(collect_pulse), 32'd0);
    chk({tag, "_all"}, 32'(all_collected), 32'd0);
    chk_state(tag);
  endtask

  int rx [2];
  int ry [2];

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0;
    level_restart = 1'b0;
    fire_x = '0; fire_y = '0; water_x = '0; water_y = '0;
    clear_model();
    repeat (3) @(negedge Clk);
    chk("reset_pulse", 32'(collect_pulse), 32'd0);
    chk("reset_all", 32'(all_collected), 32'd0);
    chk_state("reset");
    Reset = 1'b0;

    run_frame("blue0", 620, 460, 455, 400, 0, -5, -5);
    restart("rs1");
    run_frame("both", 325, 400, 455, 400, 0, -5, -5);
    restart("rs2");
    run_frame("wrong_player", 440, 400, 620, 460, 0, -5, -5);
    run_frame("touch_x", 620, 460, 480, 400, 0, -5, -5);
    run_frame("touch_x_lo", 620, 460, 440, 400, 0, -5, -5);
    run_frame("touch_y", 620, 460, 455, 380, 0, -5, -5);
    run_frame("ghost", 620, 460, 620, 460, 0, -5, 3);
    repeat (8) begin
      @(negedge Clk);
      chk("ghost_idle_pulse", 32'(collect_pulse), 32'd0);
      chk_state("ghost_idle");
    end

    run_frame("mid_restart", 325, 400, 455, 400, 1, 3, -5);
    repeat (4) begin
      @(negedge Clk);
      chk("mid_restart_idle_pulse", 32'(collect_pulse), 32'd0);
    end
    run_frame("recollect", 325, 400, 455, 400, 0, -5, -5);
    run_frame("mid_reset", 300, 215, 361, 233, 2, 4, -5);
    repeat (4) begin
      @(negedge Clk);
      chk("mid_reset_idle_pulse", 32'(collect_pulse), 32'd0);
    end

    for (int k = 0; k < 3; k++)
      run_frame($sformatf("all%0d", k), dia_x[k+3] - 5, dia_y[k+3] - 8,
                dia_x[k] - 5, dia_y[k] - 8, 0, -5, -5);
    chk("all_final", 32'(all_collected), 32'd1);
    for (int k = 0; k < 3; k++)
      run_frame($sformatf("again%0d", k), dia_x[k+3] - 5, dia_y[k+3] - 8,
                dia_x[k] - 5, dia_y[k] - 8, 0, -5, -5);
    restart("rs3");

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(7) == 0) restart("rs_rand");
      for (int p = 0; p < 2; p++) begin
        int d;
        if ($urandom_range(1) == 1) begin
          d = (p == 0) ? 3 + int'($urandom_range(2)) : int'($urandom_range(2));
          rx[p] = dia_x[d] + int'($urandom_range(48)) - 24;
          ry[p] = dia_y[d] + int'($urandom_range(48)) - 24;
        end else begin
          rx[p] = int'($urandom_range(619));
          ry[p] = int'($urandom_range(451));
        end
      end
      run_frame("rand", rx[0], ry[0], rx[1], ry[1], 0, -5, -5);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
